// File: rtl/shift_pattern_ctrl.sv
// Walking-bit / thermometer LED pattern sequencer.
// Steps a head index through an 8-bit (WIDTH) field in bounce, rotate-left,
// rotate-right or fill/drain mode. The step rate, end dwell and pass count
// are captured when a sequence starts. done pulses once on normal completion.
module shift_pattern_ctrl #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic [1:0]               mode,
    input  logic [3:0]               dwell,
    input  logic [PRESCALE_W-1:0]    prescale,
    input  logic [3:0]               passes,
    output logic [WIDTH-1:0]         pattern,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     busy,
    output logic                     done
);
    localparam int POS_W = $clog2(WIDTH);
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(WIDTH - 1);
    localparam logic [POS_W-1:0] POS_MIN = '0;
    localparam logic [1:0] MODE_BOUNCE = 2'b00;
    localparam logic [1:0] MODE_ROTL   = 2'b01;
    localparam logic [1:0] MODE_ROTR   = 2'b10;
    localparam logic [1:0] MODE_FILL   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MOVE  = 2'd1,
        S_DWELL = 2'd2
    } state_t;

    // One-hot for the walking modes, pos+1 low ones for fill/drain.
    function automatic logic [WIDTH-1:0] pattern_of(input logic [1:0] m, input logic [POS_W-1:0] p);
        logic [WIDTH:0]   therm;
        logic [WIDTH-1:0] onehot;
        therm  = ({{(WIDTH-1){1'b0}}, 2'b10} << p) - {{WIDTH{1'b0}}, 1'b1};
        onehot = {{(WIDTH-1){1'b0}}, 1'b1} << p;
        return (m == MODE_FILL) ? therm[WIDTH-1:0] : onehot;
    endfunction

    state_t                r_state, w_state_next;
    logic [POS_W-1:0]      r_pos, w_pos_next;
    logic                  r_dir, w_dir_next;          // 1 = counting up
    logic [WIDTH-1:0]      r_pattern, w_pattern_next;
    logic                  r_done, w_done_next;
    logic [1:0]            r_mode_l, w_mode_l_next;
    logic [3:0]            r_dwell_l, w_dwell_l_next;
    logic [PRESCALE_W-1:0] r_prescale_l, w_prescale_l_next;
    logic [3:0]            r_passes_l, w_passes_l_next;
    logic [PRESCALE_W-1:0] r_presc_cnt, w_presc_cnt_next;
    logic [3:0]            r_dwell_cnt, w_dwell_cnt_next;
    logic [3:0]            r_pass_cnt, w_pass_cnt_next;

    logic                  w_tick;
    logic                  w_is_bounce;
    logic                  w_arrival;
    logic                  w_complete;
    logic [POS_W-1:0]      w_step_pos;

    assign w_tick      = (r_presc_cnt == r_prescale_l);
    assign w_is_bounce = (r_mode_l == MODE_BOUNCE) || (r_mode_l == MODE_FILL);
    assign w_complete  = (r_passes_l != 4'd0) && (r_pass_cnt == r_passes_l);

    // Candidate head position for the next tick, with wrap for rotate modes.
    always_comb begin
        w_step_pos = r_dir ? r_pos + 1'b1 : r_pos - 1'b1;
        if (r_mode_l == MODE_ROTL) begin
            w_step_pos = (r_pos == POS_MAX) ? POS_MIN : r_pos + 1'b1;
        end else if (r_mode_l == MODE_ROTR) begin
            w_step_pos = (r_pos == POS_MIN) ? POS_MAX : r_pos - 1'b1;
        end
    end

    // An arrival is landing on the end position the current mode travels toward.
    always_comb begin
        if (r_mode_l == MODE_ROTL) begin
            w_arrival = (w_step_pos == POS_MAX);
        end else if (r_mode_l == MODE_ROTR) begin
            w_arrival = (w_step_pos == POS_MIN);
        end else begin
            w_arrival = (r_dir && (w_step_pos == POS_MAX)) || (!r_dir && (w_step_pos == POS_MIN));
        end
    end

    // Next-state and datapath decisions; every register holds unless told otherwise.
    always_comb begin
        w_state_next      = r_state;
        w_pos_next        = r_pos;
        w_dir_next        = r_dir;
        w_pattern_next    = r_pattern;
        w_done_next       = 1'b0;
        w_mode_l_next     = r_mode_l;
        w_dwell_l_next    = r_dwell_l;
        w_prescale_l_next = r_prescale_l;
        w_passes_l_next   = r_passes_l;
        w_presc_cnt_next  = r_presc_cnt;
        w_dwell_cnt_next  = r_dwell_cnt;
        w_pass_cnt_next   = r_pass_cnt;

        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state_next      = S_MOVE;
                    w_mode_l_next     = mode;
                    w_dwell_l_next    = dwell;
                    w_prescale_l_next = prescale;
                    w_passes_l_next   = passes;
                    w_presc_cnt_next  = '0;
                    w_dwell_cnt_next  = '0;
                    w_pass_cnt_next   = '0;
                    w_pos_next        = (mode == MODE_ROTR) ? POS_MAX : POS_MIN;
                    w_dir_next        = (mode != MODE_ROTR);
                    w_pattern_next    = pattern_of(mode, w_pos_next);
                end
            end
            S_MOVE: begin
                if (stop) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_presc_cnt_next = w_tick ? '0 : r_presc_cnt + 1'b1;
                    if (w_tick) begin
                        if (w_complete) begin
                            // Final end has been held long enough; freeze and report.
                            w_state_next = S_IDLE;
                            w_done_next  = 1'b1;
                        end else begin
                            w_pos_next     = w_step_pos;
                            w_pattern_next = pattern_of(r_mode_l, w_step_pos);
                            if (w_arrival) begin
                                w_pass_cnt_next = (r_pass_cnt == 4'hF) ? r_pass_cnt : r_pass_cnt + 1'b1;
                                // Reversing now is invisible until the hold at this end finishes.
                                if (w_is_bounce) begin
                                    w_dir_next = ~r_dir;
                                end
                                if (r_dwell_l != 4'd0) begin
                                    w_state_next     = S_DWELL;
                                    w_dwell_cnt_next = r_dwell_l;
                                end
                            end
                        end
                    end
                end
            end
            S_DWELL: begin
                if (stop) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_presc_cnt_next = w_tick ? '0 : r_presc_cnt + 1'b1;
                    if (w_tick) begin
                        w_dwell_cnt_next = r_dwell_cnt - 1'b1;
                        if (r_dwell_cnt == 4'd1) begin
                            w_state_next = S_MOVE;
                        end
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath, configuration and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos        <= '0;
            r_dir        <= 1'b1;
            r_pattern    <= {{(WIDTH-1){1'b0}}, 1'b1};
            r_done       <= 1'b0;
            r_mode_l     <= MODE_BOUNCE;
            r_dwell_l    <= '0;
            r_prescale_l <= '0;
            r_passes_l   <= '0;
            r_presc_cnt  <= '0;
            r_dwell_cnt  <= '0;
            r_pass_cnt   <= '0;
        end else begin
            r_pos        <= w_pos_next;
            r_dir        <= w_dir_next;
            r_pattern    <= w_pattern_next;
            r_done       <= w_done_next;
            r_mode_l     <= w_mode_l_next;
            r_dwell_l    <= w_dwell_l_next;
            r_prescale_l <= w_prescale_l_next;
            r_passes_l   <= w_passes_l_next;
            r_presc_cnt  <= w_presc_cnt_next;
            r_dwell_cnt  <= w_dwell_cnt_next;
            r_pass_cnt   <= w_pass_cnt_next;
        end
    end

    assign pattern = r_pattern;
    assign pos     = r_pos;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;

endmodule

// File: tb/tb_shift_pattern_ctrl.sv
// Bench for shift_pattern_ctrl: each run builds the expected per-cycle output
// trace from a position-walk model, queues it, and a monitor compares every cycle.
module tb_shift_pattern_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic [1:0] mode;
    logic [3:0] dwell;
    logic [7:0] prescale;
    logic [3:0] passes;
    logic [7:0] pattern;
    logic [2:0] pos;
    logic       busy;
    logic       done;

    typedef struct packed {
        logic [7:0] pat;
        logic [2:0] pos;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t exp_q[$];
    exp_t trace[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   run_id   = 0;
    logic [7:0] last_pat;
    logic [2:0] last_pos;

    shift_pattern_ctrl #(.WIDTH(8), .PRESCALE_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .dwell    (dwell),
        .prescale (prescale),
        .passes   (passes),
        .pattern  (pattern),
        .pos      (pos),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat_of(input int m, input int p);
        int v;
        if (m == 3) v = (2 << p) - 1;
        else        v = 1 << p;
        return v[7:0];
    endfunction

    function automatic exp_t mk(input logic [7:0] pt, input int ps, input logic b, input logic dn);
        exp_t e;
        e.pat  = pt;
        e.pos  = 3'(ps);
        e.busy = b;
        e.done = dn;
        return e;
    endfunction

    task automatic add_visit(input int m, input int ps, input int cycles, input int cap);
        for (int i = 0; i < cycles && trace.size() < cap; i++)
            trace.push_back(mk(pat_of(m, ps), ps, 1'b1, 1'b0));
    endtask

    // Walk the head position: each visited position lasts one tick, an end
    // arrival lasts 1+dwell ticks, and a tick is prescale+1 clocks.
    task automatic build(input int m, input int d, input int p, input int n,
                         input int cap, output int done_idx);
        int cur, up, arr, hold;
        bit arrived;
        trace.delete();
        done_idx = -1;
        cur = (m == 2) ? 7 : 0;
        up  = (m == 2) ? 0 : 1;
        arr = 0;
        add_visit(m, cur, p + 1, cap);
        while (trace.size() < cap) begin
            if (n != 0 && arr == n) begin
                done_idx = trace.size();
                trace.push_back(mk(pat_of(m, cur), cur, 1'b0, 1'b1));
                break;
            end
            if (m == 1)      cur = (cur + 1) % 8;
            else if (m == 2) cur = (cur + 7) % 8;
            else             cur = up ? cur + 1 : cur - 1;
            if (m == 1)      arrived = (cur == 7);
            else if (m == 2) arrived = (cur == 0);
            else             arrived = (cur == 0 || cur == 7);
            hold = 1;
            if (arrived) begin
                if (arr < 15) arr++;
                hold = 1 + d;
                if (m == 0 || m == 3) up = (cur == 0) ? 1 : 0;
            end
            add_visit(m, cur, hold * (p + 1), cap);
        end
    endtask

    // ev: 0 none, 1 stop, 2 reset, applied at relative edge 'at' (-1 = pick randomly).
    task automatic run(input int m, input int d, input int p, input int n, input int ev, input int at_in);
        int   done_idx, len, at;
        exp_t last, fz;
        at = at_in;
        build(m, d, p, n, 2000, done_idx);
        if (done_idx >= 0) len = done_idx + 4;
        else               len = at + 4;
        while (trace.size() < len) begin
            last = trace[trace.size() - 1];
            trace.push_back(mk(last.pat, int'(last.pos), 1'b0, 1'b0));
        end
        while (trace.size() > len) void'(trace.pop_back());
        if (ev != 0 && at < 1) at = $urandom_range(1, len - 2);
        if (ev == 1 && trace[at-1].busy) begin
            fz = mk(trace[at-1].pat, int'(trace[at-1].pos), 1'b0, 1'b0);
            for (int k = at; k < len; k++) trace[k] = fz;
        end
        if (ev == 2) begin
            for (int k = at; k < len; k++) trace[k] = mk(8'h01, 0, 1'b0, 1'b0);
        end

        start    = 1'b1;
        stop     = 1'b0;
        mode     = 2'(m);
        dwell    = 4'(d);
        prescale = 8'(p);
        passes   = 4'(n);
        @(posedge clk); #1;
        start = 1'b0;
        foreach (trace[k]) exp_q.push_back(trace[k]);
        for (int k = 1; k < len; k++) begin
            mode     = 2'($urandom_range(0, 3));
            dwell    = 4'($urandom_range(0, 15));
            prescale = 8'($urandom_range(0, 255));
            passes   = 4'($urandom_range(0, 15));
            reset    = (ev == 2 && k == at);
            if (trace[k-1].busy) begin
                start = ($urandom_range(0, 3) == 0);
                stop  = (ev == 1 && k == at);
            end else begin
                start = 1'b0;
                stop  = ($urandom_range(0, 1) == 1);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        last_pat = trace[len-1].pat;
        last_pos = trace[len-1].pos;
        $display("run %0d: mode=%0d dwell=%0d prescale=%0d passes=%0d event=%0d@%0d cycles=%0d",
                 run_id, m, d, p, n, ev, at, len);
        run_id++;
    endtask

    // Monitor: one comparison per cycle while expected entries are queued.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_checks++;
                if (pattern === mon_e.pat && pos === mon_e.pos &&
                    busy === mon_e.busy && done === mon_e.done) begin
                    n_pass++;
                end else begin
                    $display("FAIL cycle_check #%0d: got pattern=%h pos=%0d busy=%b done=%b, expected pattern=%h pos=%0d busy=%b done=%b",
                             n_checks, pattern, pos, busy, done, mon_e.pat, mon_e.pos, mon_e.busy, mon_e.done);
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int m, d, p, n, ev, at;
        reset = 1'b1; start = 1'b0; stop = 1'b0;
        mode = 2'd0; dwell = 4'd0; prescale = 8'd0; passes = 4'd0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) exp_q.push_back(mk(8'h01, 0, 1'b0, 1'b0));
        for (int k = 1; k < 5; k++) begin
            stop = ($urandom_range(0, 1) == 1);
            mode = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        stop = 1'b0;
        $display("run reset: idle after reset, 5 cycles");

        run(0, 0, 0, 2, 0, 0);     // bounce, two passes
        run(0, 3, 0, 2, 0, 0);     // bounce with end dwell
        run(2, 0, 2, 0, 1, 40);    // rotate-right forever, stopped

        // start and stop together in idle: nothing moves
        start = 1'b1; stop = 1'b1; mode = 2'd1;
        @(posedge clk); #1;
        start = 1'b0; stop = 1'b0;
        for (int k = 0; k < 4; k++) exp_q.push_back(mk(last_pat, int'(last_pos), 1'b0, 1'b0));
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
        end
        $display("run start+stop: stays idle, 4 cycles");

        run(3, 0, 0, 2, 0, 0);     // fill/drain
        run(1, 1, 1, 1, 0, 0);     // rotate-left, one pass
        run(0, 5, 1, 0, 2, 18);    // reset during top-end dwell

        for (int r = 0; r < 30; r++) begin
            m = $urandom_range(0, 3);
            d = $urandom_range(0, 5);
            p = $urandom_range(0, 3);
            n = $urandom_range(0, 3);
            if (n == 0) begin
                ev = $urandom_range(1, 2);
                at = $urandom_range(5, 80);
            end else begin
                ev = $urandom_range(0, 2);
                at = -1;
            end
            run(m, d, p, n, ev, at);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/shift_pattern_ctrl.md
Name: shift_pattern_ctrl

Overview:
Sequencer for the 8-bit LED shift datapath. It generates a walking-bit or thermometer pattern in one of four modes. Programmable step rate, end-of-travel dwell and pass count are latched at start. The block sits between the board-level control (start/stop/config switches) and the LED/pattern output. It owns all stepping, direction and dwell decisions in a single clock domain.

Parameters:
WIDTH, 8, pattern width in bits (at least 2)
PRESCALE_W, 8, width of the step-rate prescaler field

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset; priority over all other inputs
start  input  1  begin sequence; sampled only in IDLE
stop  input  1  abort sequence; sampled in MOVE/DWELL, and in IDLE it blocks start
mode  input  2  00 bounce, 01 rotate-left, 10 rotate-right, 11 fill/drain
dwell  input  4  extra ticks to hold at an end position
prescale  input  PRESCALE_W  a step tick occurs every prescale+1 clocks
passes  input  4  number of end arrivals before done; 0 means run forever
pattern  output  WIDTH  registered pattern
pos  output  clog2(WIDTH)  head index
busy  output  1  high in MOVE/DWELL
done  output  1  one-cycle pulse on normal completion

Behaviour:
- Reset values: state IDLE, pattern=1, pos=0, busy=0, done=0. The prescaler counter, dwell counter, pass counter and dir (up) are cleared.
- Config latching: mode, dwell, prescale and passes are captured on the start edge. Later changes are ignored until the next start.
- Tick: the prescaler counts 0..prescale_l only in MOVE/DWELL. A tick fires when the counter equals prescale_l, and the counter then returns to 0. prescale=0 means a tick every cycle. The counter is cleared on start.
- IDLE handling:
  - start=1 and stop=0 moves the FSM to MOVE on the same edge.
  - pos is loaded as WIDTH-1 for rotate-right, otherwise 0.
  - dir is set to up (down for rotate-right).
  - The pattern is loaded accordingly, so the start value is visible on the cycle after the start edge.
  - start and stop together leave the FSM in IDLE.
- Pattern encoding:
  - Modes 00/01/10 are one-hot: pattern = 1<<pos.
  - Mode 11 is thermometer: pattern = (2<<pos)-1, giving pos+1 ones.
- MOVE, on each tick:
  - Bounce/fill: pos steps by ±1 in dir.
  - Rotate-left: pos+1, wrapping WIDTH-1 to 0.
  - Rotate-right: pos-1, wrapping 0 to WIDTH-1.
- Arrival events:
  - Bounce/fill: pos becomes WIDTH-1 moving up, or 0 moving down.
  - Rotate-left: pos becomes WIDTH-1.
  - Rotate-right: pos becomes 0.
  - On arrival the pass counter increments. If dwell_l≠0 the FSM enters DWELL with the dwell counter loaded to dwell_l.
- End occupancy: each end position is held for exactly 1+dwell_l ticks.
  - At the end of that hold, bounce/fill invert dir.
  - Rotate modes keep dir, so the next tick wraps.
- DWELL: the dwell counter decrements on each tick. When it reaches 0, the FSM returns to MOVE and the direction rule above is applied.
- Completion: when passes_l≠0 and the pass counter equals passes_l, the final end is still held 1+dwell_l ticks. On the next tick the FSM enters IDLE with done=1 for exactly that cycle and busy=0. pattern and pos are frozen at the final value.
- Stop: stop=1 in MOVE/DWELL sends the FSM to IDLE on the next edge. busy drops, pattern freezes and done stays 0.
- Other boundaries:
  - start while busy is ignored.
  - passes=0 never completes.
  - The pass counter saturates and never wraps.
  - reset mid-run restores all reset values on the next edge, regardless of tick or state.

Test Plan:
1. Assert reset for 2 cycles, then release. Expect pattern=0x01, pos=0, busy=0, done=0, and no change without start.
2. Bounce, prescale=0, dwell=0, passes=2, start at edge 0.
   - Edges 1–7: pattern goes 0x02..0x80.
   - Edges 8–14: pattern goes 0x40..0x01.
   - Edge 15: busy=0, done=1 for one cycle, pattern=0x01.
3. Bounce, dwell=3, prescale=0. Expect 0x80 to be held for exactly 4 consecutive cycles, then 0x40. Expect 0x01 to also be held 4 cycles at the low end.
4. Rotate-right, prescale=2, passes=0.
   - Start gives 0x80; the pattern then changes every 3 cycles down to 0x01, then wraps to 0x80.
   - stop mid-run: busy=0 next cycle, pattern frozen, done never pulses.
5. Fill, prescale=0, passes=2. Expect 0x01,0x03,0x07..0xFF, then 0x7F..0x01, then done. Changing mode/prescale mid-run has no effect.
6. Corner cases:
   - start+stop together in IDLE: stays IDLE.
   - reset asserted during DWELL: pattern=0x01, busy=0 next cycle.
   - start while busy: ignored, with no sequence restart.
